// File: rtl/pid_suma_pwm.sv
// pid_suma_pwm -- final PID stage: sums the P, I and D terms, scales and saturates the
// result into an unsigned duty word, and drives a free-running PWM output.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   etapa6   one-cycle strobe, Psal/Isal/Dsal valid
//   Psal     proportional term, 18-bit signed
//   Isal     integral term, 18-bit signed
//   Dsal     derivative term, 18-bit signed
//   duty     registered saturated duty (pending value)
//   sat_hi   last update clipped high
//   sat_lo   last update clipped low (negative)
//   listo    one-cycle pulse, new duty valid
//   pwm      registered PWM output
//
// Parameters: DUTY_W (duty/counter width, <= 31), SHIFT (arithmetic right shift of the
// sum), PRESC (clocks per PWM tick, >= 1).
//
// Configuration macro PID_PWM_SYNC_UPDATE_EN:
//   defined     -> the active duty loads from duty only when the PWM counter wraps to 0
//   not defined -> the active duty follows duty directly (may change mid-period)

module pid_suma_pwm #(
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned SHIFT  = 8,
    parameter int unsigned PRESC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              etapa6,
    input  logic [17:0]       Psal,
    input  logic [17:0]       Isal,
    input  logic [17:0]       Dsal,
    output logic [DUTY_W-1:0] duty,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              listo,
    output logic              pwm
);

    localparam int unsigned PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int          DMAX = (1 << DUTY_W) - 1;

    // Sum / scale / saturate datapath
    logic signed [19:0] sum;
    logic signed [19:0] q;
    logic signed [31:0] q_ext;
    logic [DUTY_W-1:0]  duty_new;
    logic               hi_new;
    logic               lo_new;

    // Three 18-bit terms need at most 20 bits, so the sum cannot overflow.
    assign sum   = {{2{Psal[17]}}, Psal} + {{2{Isal[17]}}, Isal} + {{2{Dsal[17]}}, Dsal};
    assign q     = sum >>> SHIFT;
    assign q_ext = 32'(q);

    always_comb begin
        duty_new = '0;
        hi_new   = 1'b0;
        lo_new   = 1'b0;
        if (q_ext < 0) begin
            lo_new = 1'b1;
        end else if (q_ext > DMAX) begin
            duty_new = '1;
            hi_new   = 1'b1;
        end else begin
            duty_new = DUTY_W'(q_ext);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty   <= '0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
            listo  <= 1'b0;
        end else begin
            if (etapa6) begin
                duty   <= duty_new;
                sat_hi <= hi_new;
                sat_lo <= lo_new;
            end
            listo <= etapa6;
        end
    end

    // PWM timebase
    logic [PW-1:0]     presc_q;
    logic [DUTY_W-1:0] cnt_q;
    logic [DUTY_W-1:0] duty_act;
    logic              tick;
    logic              wrap;

    assign tick = (presc_q == PW'(PRESC - 1));
    assign wrap = tick && (cnt_q == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            pwm     <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                cnt_q <= cnt_q + DUTY_W'(1);
            end
            pwm <= (cnt_q < duty_act);
        end
    end

`ifdef PID_PWM_SYNC_UPDATE_EN
    // Loading on the wrap edge picks up the pre-strobe duty when a strobe coincides,
    // so every period runs with a single duty value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_act <= '0;
        end else if (wrap) begin
            duty_act <= duty;
        end
    end
`else
    assign duty_act = duty;

    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

endmodule
